// File: rtl/poly_tone_mixer.sv
`default_nettype none
// ============================================================================
// Module      : poly_tone_mixer
// Description : Polyphonic square-wave synthesizer with voice allocation,
//               oldest-voice stealing and saturating stereo mixdown.
// Revision    : 1.0 - initial release
// ============================================================================
module poly_tone_mixer #(
    parameter int          NUM_VOICES = 4,
    parameter int          DIV_W      = 20,
    parameter logic [15:0] AMP        = 16'h1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    note_on,
    input  logic                    note_off,
    input  logic [DIV_W-1:0]        note_div,
    input  logic                    stereo,
    output logic signed [15:0]      audio_left,
    output logic signed [15:0]      audio_right,
    output logic [NUM_VOICES-1:0]   voice_busy,
    output logic                    steal
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int SUM_W = 16 + $clog2(NUM_VOICES) + 1;
    localparam int AGE_W = 8;

    localparam logic [AGE_W-1:0]        AGE_MAX = {AGE_W{1'b1}};
    localparam logic signed [SUM_W-1:0] AMP_S   = SUM_W'({1'b0, AMP});
    localparam logic signed [SUM_W-1:0] SAT_HI  = SUM_W'(32767);
    localparam logic signed [SUM_W-1:0] SAT_LO  = SUM_W'(-32768);

    // ------------------------------------------------------------------
    // Voice state
    // ------------------------------------------------------------------
    logic [NUM_VOICES-1:0] active_q, active_d;
    logic [NUM_VOICES-1:0] phase_q,  phase_d;
    logic [DIV_W-1:0]      div_q [NUM_VOICES];
    logic [DIV_W-1:0]      div_d [NUM_VOICES];
    logic [DIV_W-1:0]      cnt_q [NUM_VOICES];
    logic [DIV_W-1:0]      cnt_d [NUM_VOICES];
    logic [AGE_W-1:0]      age_q [NUM_VOICES];
    logic [AGE_W-1:0]      age_d [NUM_VOICES];

    logic                  steal_q, steal_d;
    logic signed [15:0]    left_q,  left_d;
    logic signed [15:0]    right_q, right_d;

    // ------------------------------------------------------------------
    // Allocation decode
    // ------------------------------------------------------------------
    logic                  w_on_valid;
    logic [NUM_VOICES-1:0] w_off_hit;
    logic [NUM_VOICES-1:0] w_live;
    logic [NUM_VOICES-1:0] w_match;
    logic                  w_has_match;
    logic                  w_has_free;
    logic [IDX_W-1:0]      w_match_idx;
    logic [IDX_W-1:0]      w_free_idx;
    logic [IDX_W-1:0]      w_old_idx;
    logic [AGE_W-1:0]      w_old_age;
    logic [IDX_W-1:0]      w_sel_idx;

    always_comb begin
        w_on_valid = note_on && (note_div != '0);

        // note_off is resolved first so a same-cycle note_on sees the freed voices
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_off_hit[i] = note_off && active_q[i] && (div_q[i] == note_div);
            w_live[i]    = active_q[i] && !w_off_hit[i];
            w_match[i]   = w_live[i] && (div_q[i] == note_div);
        end

        w_has_match = |w_match;
        w_has_free  = ~&w_live;

        w_match_idx = '0;
        w_free_idx  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_match_idx = IDX_W'(i);
            end
            if (!w_live[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end

        // Strict compare keeps the lowest index on equal ages
        w_old_idx = '0;
        w_old_age = age_q[0];
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (age_q[i] > w_old_age) begin
                w_old_age = age_q[i];
                w_old_idx = IDX_W'(i);
            end
        end

        if (w_has_match) begin
            w_sel_idx = w_match_idx;
        end else if (w_has_free) begin
            w_sel_idx = w_free_idx;
        end else begin
            w_sel_idx = w_old_idx;
        end
    end

    // ------------------------------------------------------------------
    // Voice next-state
    // ------------------------------------------------------------------
    always_comb begin
        steal_d = w_on_valid && !w_has_match && !w_has_free;

        for (int i = 0; i < NUM_VOICES; i++) begin
            active_d[i] = w_live[i];
            div_d[i]    = div_q[i];
            age_d[i]    = age_q[i];
            cnt_d[i]    = '0;
            phase_d[i]  = 1'b0;

            if (w_live[i]) begin
                if (cnt_q[i] == div_q[i] - DIV_W'(1)) begin
                    cnt_d[i]   = '0;
                    phase_d[i] = ~phase_q[i];
                end else begin
                    cnt_d[i]   = cnt_q[i] + DIV_W'(1);
                    phase_d[i] = phase_q[i];
                end
                if (w_on_valid && (age_q[i] != AGE_MAX)) begin
                    age_d[i] = age_q[i] + AGE_W'(1);
                end
            end else begin
                age_d[i] = '0;
            end

            if (w_on_valid && (IDX_W'(i) == w_sel_idx)) begin
                active_d[i] = 1'b1;
                div_d[i]    = note_div;
                cnt_d[i]    = '0;
                phase_d[i]  = 1'b0;
                age_d[i]    = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mixdown
    // ------------------------------------------------------------------
    function automatic logic signed [15:0] sat16(input logic signed [SUM_W-1:0] s);
        if (s > SAT_HI) begin
            return 16'sh7FFF;
        end else if (s < SAT_LO) begin
            return 16'sh8000;
        end
        return s[15:0];
    endfunction

    logic signed [SUM_W-1:0] w_sum_l;
    logic signed [SUM_W-1:0] w_sum_r;
    logic signed [SUM_W-1:0] w_contrib;

    always_comb begin
        w_sum_l   = '0;
        w_sum_r   = '0;
        w_contrib = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!active_q[i]) begin
                w_contrib = '0;
            end else if (phase_q[i]) begin
                w_contrib = AMP_S;
            end else begin
                w_contrib = -AMP_S;
            end
            // Stereo routes even voices left and odd voices right
            if (!stereo || ((i % 2) == 0)) begin
                w_sum_l = w_sum_l + w_contrib;
            end
            if (!stereo || ((i % 2) == 1)) begin
                w_sum_r = w_sum_r + w_contrib;
            end
        end
        left_d  = sat16(w_sum_l);
        right_d = sat16(w_sum_r);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= '0;
            phase_q  <= '0;
            steal_q  <= 1'b0;
            left_q   <= '0;
            right_q  <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                div_q[i] <= '0;
                cnt_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            steal_q  <= steal_d;
            left_q   <= left_d;
            right_q  <= right_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
                age_q[i] <= age_d[i];
            end
        end
    end

    assign audio_left  = left_q;
    assign audio_right = right_q;
    assign voice_busy  = active_q;
    assign steal       = steal_q;

endmodule
`default_nettype wire

// File: tb/tb_poly_tone_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tb_poly_tone_mixer
// Description : Directed plus random bench for poly_tone_mixer, two amplitudes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_tone_mixer;

    localparam int NV    = 4;
    localparam int DW    = 20;
    localparam int AMP_A = 4096;
    localparam int AMP_B = 28672;

    logic               clk = 1'b0;
    logic               rst;
    logic               note_on;
    logic               note_off;
    logic [DW-1:0]      note_div;
    logic               stereo;
    logic signed [15:0] left_a, right_a, left_b, right_b;
    logic [NV-1:0]      busy_a, busy_b;
    logic               steal_a, steal_b;

    always #5 clk = ~clk;

    poly_tone_mixer #(.NUM_VOICES(NV), .DIV_W(DW), .AMP(16'h1000)) dut_a (
        .clk(clk), .rst(rst), .note_on(note_on), .note_off(note_off),
        .note_div(note_div), .stereo(stereo),
        .audio_left(left_a), .audio_right(right_a),
        .voice_busy(busy_a), .steal(steal_a)
    );

    poly_tone_mixer #(.NUM_VOICES(NV), .DIV_W(DW), .AMP(16'h7000)) dut_b (
        .clk(clk), .rst(rst), .note_on(note_on), .note_off(note_off),
        .note_div(note_div), .stereo(stereo),
        .audio_left(left_b), .audio_right(right_b),
        .voice_busy(busy_b), .steal(steal_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a voice is described by its start edge and trigger
    // event number; phase and age are derived arithmetically from those.
    bit        m_act   [NV];
    int        m_div   [NV];
    int        m_start [NV];
    int        m_stamp [NV];
    int        edge_n;
    int        nev;
    int        exp_l_a, exp_r_a, exp_l_b, exp_r_b;
    logic [NV-1:0] exp_busy;
    bit        exp_steal;

    function automatic int clamp16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int vsign(input int v);
        if (!m_act[v]) return 0;
        return ((((edge_n - m_start[v]) / m_div[v]) % 2) == 1) ? 1 : -1;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_act[v] = 0; m_div[v] = 0; m_start[v] = 0; m_stamp[v] = 0;
        end
        edge_n = 0; nev = 0;
        exp_l_a = 0; exp_r_a = 0; exp_l_b = 0; exp_r_b = 0;
        exp_busy = '0; exp_steal = 0;
    endtask

    task automatic model_edge(input bit on, input bit off, input int d, input bit st);
        int sl, sr, pick, best, age;
        sl = 0; sr = 0; pick = -1; best = -1;
        for (int v = 0; v < NV; v++) begin
            if (!st || (v % 2) == 0) sl += vsign(v);
            if (!st || (v % 2) == 1) sr += vsign(v);
        end
        exp_l_a = clamp16(sl * AMP_A); exp_r_a = clamp16(sr * AMP_A);
        exp_l_b = clamp16(sl * AMP_B); exp_r_b = clamp16(sr * AMP_B);
        exp_steal = 0;
        if (off) begin
            for (int v = 0; v < NV; v++)
                if (m_act[v] && m_div[v] == d) m_act[v] = 0;
        end
        if (on && d != 0) begin
            for (int v = 0; v < NV; v++)
                if (pick < 0 && m_act[v] && m_div[v] == d) pick = v;
            for (int v = 0; v < NV; v++)
                if (pick < 0 && !m_act[v]) pick = v;
            if (pick < 0) begin
                exp_steal = 1;
                for (int v = 0; v < NV; v++) begin
                    age = nev - m_stamp[v];
                    if (age > 255) age = 255;
                    if (age > best) begin best = age; pick = v; end
                end
            end
            nev++;
            m_act[pick] = 1; m_div[pick] = d;
            m_start[pick] = edge_n + 1; m_stamp[pick] = nev;
        end
        edge_n++;
        for (int v = 0; v < NV; v++) exp_busy[v] = m_act[v];
    endtask

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s @%0t: observed %0d expected %0d", tag, $time, got, want);
        end
    endtask

    task automatic check_all();
        chk("left_a",  left_a,  exp_l_a);
        chk("right_a", right_a, exp_r_a);
        chk("left_b",  left_b,  exp_l_b);
        chk("right_b", right_b, exp_r_b);
        chk("busy_a",  {28'd0, busy_a}, {28'd0, exp_busy});
        chk("busy_b",  {28'd0, busy_b}, {28'd0, exp_busy});
        chk("steal_a", {31'd0, steal_a}, {31'd0, exp_steal});
        chk("steal_b", {31'd0, steal_b}, {31'd0, exp_steal});
    endtask

    task automatic tick(input bit on, input bit off, input int d);
        note_on = on; note_off = off; note_div = DW'(d);
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(on, off, d, stereo);
        #1;
        note_on = 1'b0; note_off = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(0, 0, 0);
        tick(1, 0, 5);      // pulse coinciding with reset must be dropped
        rst = 1'b0;
    endtask

    initial begin
        logic [NV-1:0] busy_snap;
        bit saw_hi, saw_lo;
        rst = 1'b1; note_on = 1'b0; note_off = 1'b0; note_div = '0; stereo = 1'b0;
        model_reset();
        #1;
        chk("por_left", left_a, 0);
        chk("por_busy", {28'd0, busy_a}, 0);

        // Single voice, half period 4
        do_reset();
        tick(1, 0, 4);
        chk("single_busy", {28'd0, busy_a}, 32'd1);
        idle(14);

        // Fill four voices then steal the oldest
        do_reset();
        tick(1, 0, 3); tick(1, 0, 5); tick(1, 0, 7); tick(1, 0, 9);
        tick(1, 0, 11);
        chk("steal_pulse", {31'd0, steal_a}, 32'd1);
        chk("steal_busy",  {28'd0, busy_a}, 32'hF);
        tick(0, 0, 0);
        chk("steal_drop",  {31'd0, steal_a}, 32'd0);
        idle(20);
        tick(1, 0, 7);      // retrigger, no steal
        chk("retrig_nosteal", {31'd0, steal_a}, 32'd0);
        idle(6);

        // Stereo routing
        do_reset();
        tick(1, 0, 4); tick(1, 0, 6);
        stereo = 1'b1; idle(16);
        stereo = 1'b0; idle(8);

        // Same-cycle off/on for one div, then div=0 ignored
        tick(1, 1, 4);
        idle(5);
        busy_snap = busy_a;
        tick(1, 0, 0);
        chk("div0_busy", {28'd0, busy_a}, {28'd0, busy_snap});
        tick(0, 1, 6);
        idle(5);

        // Saturation on the high-amplitude instance
        do_reset();
        tick(1, 0, 50); tick(1, 0, 51); tick(1, 0, 52); tick(1, 0, 53);
        saw_hi = 0; saw_lo = 0;
        for (int k = 0; k < 70; k++) begin
            tick(0, 0, 0);
            if (left_b == 16'sh7FFF) saw_hi = 1;
            if (left_b == 16'sh8000) saw_lo = 1;
        end
        chk("sat_hi_seen", {31'd0, saw_hi}, 32'd1);
        chk("sat_lo_seen", {31'd0, saw_lo}, 32'd1);

        // Asynchronous reset mid-tone
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_left",  left_a,  0);
        chk("async_right", right_b, 0);
        chk("async_busy",  {28'd0, busy_a}, 0);
        tick(1, 1, 4);
        rst = 1'b0;
        idle(2);

        // Randomized traffic
        for (int k = 0; k < 500; k++) begin
            bit on, off;
            int d;
            if ($urandom_range(0, 59) == 0) rst = 1'b1;
            if ($urandom_range(0, 19) == 0) stereo = ~stereo;
            on  = ($urandom_range(0, 2) == 0);
            off = ($urandom_range(0, 4) == 0);
            d   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(7, 40))
                                               : int'($urandom_range(0, 6));
            tick(on, off, d);
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
